pipe_chain: RTL and testbench

- Parametrised, elastic replacement for the fixed if_id/id_ex/ex_mem/mem_wb register chain.
- STAGES back-to-back skid-buffered stages, each with a valid/ready handshake.
- Per-stage flush for branch redirect and exception kill.
- Sits between producer and consumer pipeline logic in the core; stage payload is opaque.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_chain_if.sv | 11 +
 rtl/pipe_skid_stage.sv | 47 ++++
 rtl/pipe_chain.sv | 90 +++++++++
 tb/tb_pipe_chain.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline register chain.
package pipe_pkg;

   localparam int unsigned MAX_STAGES = 8;
   // Wide enough for 0..2*MAX_STAGES held payloads
   localparam int unsigned OCC_W      = $clog2(2 * MAX_STAGES + 1);

   // Per-stage control: upstream valid, downstream ready, flush
   typedef struct packed {
      logic valid;
      logic ready;
      logic flush;
   } stage_ctrl_t;

endpackage

// File: rtl/pipe_chain_if.sv
// Valid/ready/data handshake bundle used on both ends of the pipeline chain.
interface pipe_chain_if #(
   parameter int unsigned DATA_W = 64
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// One skid-buffered pipeline stage: main register M feeds downstream, skid S absorbs
// one extra payload so that the upstream ready is purely registered (!S_valid).
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  stage_ctrl_t       ctrl,
   input  logic [DATA_W-1:0] up_data,
   output logic              dn_valid,
   output logic [DATA_W-1:0] dn_data,
   output logic              skid_valid
);

   logic [DATA_W-1:0] skid_data;
   logic              take;
   logic              put;

   assign take = dn_valid && ctrl.ready;
   assign put  = ctrl.valid && !skid_valid;

   // Flush only drops stored state; the upstream handshake still completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dn_valid   <= 1'b0;
         dn_data    <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (ctrl.flush) begin
         dn_valid   <= 1'b0;
         skid_valid <= 1'b0;
      end else if (put && (!dn_valid || take)) begin
         dn_valid <= 1'b1;
         dn_data  <= up_data;
      end else if (put) begin
         skid_valid <= 1'b1;
         skid_data  <= up_data;
      end else if (take) begin
         dn_valid   <= skid_valid;
         dn_data    <= skid_data;
         skid_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_chain.sv
// Parametrised chain of STAGES skid-buffered stages with per-stage flush.
// Optional saturating output-bubble counter enabled by PIPE_BUBBLE_CNT_EN.
module pipe_chain
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned STAGES = 4,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   pipe_chain_if.slave       up,
   pipe_chain_if.master      dn,
   input  logic [STAGES-1:0] flush_mask,
   output logic [STAGES-1:0] stage_valid,
   output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_BUBBLE_CNT_EN
   ,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   if (STAGES < 1 || STAGES > MAX_STAGES || CNT_W < 1) begin : g_bad_cfg
      $error("pipe_chain: illegal STAGES or CNT_W");
   end

   stage_ctrl_t       ctrl    [STAGES];
   logic [DATA_W-1:0] in_data [STAGES];
   logic [DATA_W-1:0] m_data  [STAGES];
   logic [STAGES-1:0] m_valid;
   logic [STAGES-1:0] s_valid;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic up_v;
      logic dn_r;

      if (i == 0) begin : g_head
         assign up_v       = up.valid;
         assign in_data[i] = up.data;
      end else begin : g_body
         assign up_v       = m_valid[i-1];
         assign in_data[i] = m_data[i-1];
      end

      if (i == STAGES - 1) begin : g_tail
         assign dn_r = dn.ready;
      end else begin : g_link
         assign dn_r = !s_valid[i+1];
      end

      assign ctrl[i] = '{valid: up_v, ready: dn_r, flush: flush_mask[i]};

      pipe_skid_stage #(
         .DATA_W (DATA_W)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .ctrl       (ctrl[i]),
         .up_data    (in_data[i]),
         .dn_valid   (m_valid[i]),
         .dn_data    (m_data[i]),
         .skid_valid (s_valid[i])
      );
   end

   assign up.ready    = !s_valid[0];
   assign dn.valid    = m_valid[STAGES-1];
   assign dn.data     = m_data[STAGES-1];
   assign stage_valid = m_valid | s_valid;

   // Population count of every held payload, straight from flops
   always_comb begin
      occupancy = '0;
      for (int i = 0; i < STAGES; i++) begin
         occupancy = occupancy + OCC_W'(m_valid[i]) + OCC_W'(s_valid[i]);
      end
   end

`ifdef PIPE_BUBBLE_CNT_EN
   // Counts cycles the consumer was ready but had nothing to take
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt <= '0;
      end else if (dn.ready && !dn.valid && (bubble_cnt != '1)) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain: queue-per-stage reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_pipe_chain;
   import pipe_pkg::*;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned STAGES = 4;
   localparam int unsigned CNT_W  = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [STAGES-1:0] flush_mask;
   logic [STAGES-1:0] stage_valid;
   logic [OCC_W-1:0]  occupancy;
`ifdef PIPE_BUBBLE_CNT_EN
   logic [CNT_W-1:0]  bubble_cnt;
`endif

   pipe_chain_if #(.DATA_W(DATA_W)) up_if ();
   pipe_chain_if #(.DATA_W(DATA_W)) dn_if ();

   pipe_chain #(
      .DATA_W (DATA_W),
      .STAGES (STAGES),
      .CNT_W  (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .up          (up_if),
      .dn          (dn_if),
      .flush_mask  (flush_mask),
      .stage_valid (stage_valid),
      .occupancy   (occupancy)
`ifdef PIPE_BUBBLE_CNT_EN
      ,
      .bubble_cnt  (bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each stage is an ordered queue of at most two payloads
   logic [DATA_W-1:0] md [STAGES][2];
   int                mn [STAGES];
   logic              tr [STAGES+1];
   logic [DATA_W-1:0] mv [STAGES];
   logic [CNT_W-1:0]  bub;
   logic [DATA_W-1:0] dut_log [$];

   function automatic void model_step();
      for (int i = 0; i < STAGES; i++) mv[i] = (i == 0) ? up_if.data : md[i-1][0];
      tr[0] = up_if.valid && (mn[0] < 2);
      for (int i = 1; i < STAGES; i++) tr[i] = (mn[i-1] > 0) && (mn[i] < 2);
      tr[STAGES] = (mn[STAGES-1] > 0) && dn_if.ready;
      if (dn_if.ready && (mn[STAGES-1] == 0) && (bub != {CNT_W{1'b1}})) bub = bub + 1'b1;
      for (int i = 0; i < STAGES; i++) begin
         if (tr[i+1]) begin
            md[i][0] = md[i][1];
            mn[i]    = mn[i] - 1;
         end
      end
      for (int i = 0; i < STAGES; i++) begin
         if (tr[i]) begin
            md[i][mn[i]] = mv[i];
            mn[i]        = mn[i] + 1;
         end
      end
      for (int i = 0; i < STAGES; i++) if (flush_mask[i]) mn[i] = 0;
   endfunction

   // Advance model on each edge, then compare just after the edge
   always @(posedge clk) begin
      int          occ;
      logic [STAGES-1:0] sv;
      if (rst) begin
         for (int i = 0; i < STAGES; i++) mn[i] = 0;
         bub = '0;
      end else begin
         if (dn_if.valid && dn_if.ready) dut_log.push_back(dn_if.data);
         model_step();
      end
      #1;
      occ = 0;
      for (int i = 0; i < STAGES; i++) begin
         occ   = occ + mn[i];
         sv[i] = (mn[i] > 0);
      end
      chk("in_ready", 32'(up_if.ready), 32'(mn[0] < 2));
      chk("out_valid", 32'(dn_if.valid), 32'(mn[STAGES-1] > 0));
      if (mn[STAGES-1] > 0) chk("out_data", 32'(dn_if.data), 32'(md[STAGES-1][0]));
      chk("occupancy", 32'(occupancy), 32'(occ));
      chk("stage_valid", 32'(stage_valid), 32'(sv));
`ifdef PIPE_BUBBLE_CNT_EN
      chk("bubble_cnt", 32'(bubble_cnt), 32'(bub));
`endif
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_seen;
      int gaps;
      int idx;

      rst          = 1'b1;
      up_if.valid  = 1'b0;
      up_if.data   = '0;
      dn_if.ready  = 1'b0;
      flush_mask   = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(up_if.ready), 32'd1);
      chk("rst_out_valid", 32'(dn_if.valid), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_out_data", 32'(dn_if.data), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", 32'(up_if.ready), 32'd1);

      // Streaming 0x11..0x18
      dn_if.ready = 1'b1;
      first_seen  = -1;
      gaps        = 0;
      dut_log.delete();
      for (int c = 0; c < 14; c++) begin
         up_if.valid = (c < 8);
         up_if.data  = 16'(16'h11 + c);
         @(negedge clk);
         if (dn_if.valid && first_seen < 0) first_seen = c + 1;
         if ((c + 1) >= 4 && (c + 1) <= 11 && !dn_if.valid) gaps++;
      end
      up_if.valid = 1'b0;
      chk("stream_latency", 32'(first_seen), 32'd4);
      chk("stream_gaps", 32'(gaps), 32'd0);
      chk("stream_count", 32'(dut_log.size()), 32'd8);
      if (dut_log.size() == 8)
         for (int k = 0; k < 8; k++) chk($sformatf("stream_%0d", k), 32'(dut_log[k]), 32'(16'h11 + k));

      // Backpressure: 10 offered, 8 absorbed, then drain
      dn_if.ready = 1'b0;
      idx = 0;
      dut_log.delete();
      for (int c = 0; c < 20; c++) begin
         up_if.valid = (idx < 10);
         up_if.data  = 16'(16'h30 + idx);
         if (up_if.ready && idx < 10) idx++;
         @(negedge clk);
      end
      chk("bp_accepted", 32'(idx), 32'd8);
      chk("bp_in_ready", 32'(up_if.ready), 32'd0);
      chk("bp_occupancy", 32'(occupancy), 32'd8);
      dn_if.ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         up_if.valid = (idx < 10);
         up_if.data  = 16'(16'h30 + idx);
         if (up_if.ready && idx < 10) idx++;
         @(negedge clk);
      end
      up_if.valid = 1'b0;
      chk("bp_drain_count", 32'(dut_log.size()), 32'd10);
      if (dut_log.size() == 10)
         for (int k = 0; k < 10; k++) chk($sformatf("bp_%0d", k), 32'(dut_log[k]), 32'(16'h30 + k));

      // Partial flush of stages 0 and 1 while streaming
      dut_log.delete();
      for (int c = 0; c < 4; c++) begin
         up_if.valid = 1'b1;
         up_if.data  = 16'(16'hA0 + c);
         @(negedge clk);
      end
      up_if.valid = 1'b0;
      flush_mask  = 4'b0011;
      @(negedge clk);
      flush_mask  = '0;
      up_if.valid = 1'b1;
      up_if.data  = 16'hA4;
      @(negedge clk);
      up_if.valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("pflush_count", 32'(dut_log.size()), 32'd4);
      if (dut_log.size() == 4) begin
         chk("pflush_0", 32'(dut_log[0]), 32'hA0);
         chk("pflush_1", 32'(dut_log[1]), 32'hA1);
         chk("pflush_2", 32'(dut_log[2]), 32'hA2);
         chk("pflush_3", 32'(dut_log[3]), 32'hA4);
      end

      // Full flush with an input arriving on the same edge
      dn_if.ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         up_if.valid = 1'b1;
         up_if.data  = 16'(16'h61 + c);
         @(negedge clk);
      end
      chk("fflush_in_ready", 32'(up_if.ready), 32'd1);
      flush_mask  = '1;
      up_if.data  = 16'h55;
      dut_log.delete();
      @(negedge clk);
      flush_mask  = '0;
      up_if.valid = 1'b0;
      chk("fflush_occupancy", 32'(occupancy), 32'd0);
      chk("fflush_ready", 32'(up_if.ready), 32'd1);
      dn_if.ready = 1'b1;
      repeat (8) @(negedge clk);
      chk("fflush_no_output", 32'(dut_log.size()), 32'd0);

      // Randomised traffic with occasional flushes
      for (int c = 0; c < 2000; c++) begin
         up_if.valid = ($urandom_range(0, 3) != 0);
         up_if.data  = 16'($urandom);
         dn_if.ready = ($urandom_range(0, 3) != 0);
         flush_mask  = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
         @(negedge clk);
      end
      up_if.valid = 1'b0;
      flush_mask  = '0;
      dn_if.ready = 1'b0;
      repeat (2) @(negedge clk);

      // Asynchronous reset while payloads are held
      for (int c = 0; c < 4; c++) begin
         up_if.valid = 1'b1;
         up_if.data  = 16'(16'hC0 + c);
         @(negedge clk);
      end
      up_if.valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(dn_if.valid), 32'd0);
      chk("arst_occupancy", 32'(occupancy), 32'd0);
      chk("arst_in_ready", 32'(up_if.ready), 32'd1);
      chk("arst_stage_valid", 32'(stage_valid), 32'd0);
      chk("arst_out_data", 32'(dn_if.data), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      dn_if.ready = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_rst_occupancy", 32'(occupancy), 32'd0);
`ifdef PIPE_BUBBLE_CNT_EN
      chk("bubble_six", 32'(bubble_cnt), 32'd6);
      repeat (4) @(negedge clk);
      chk("bubble_sat", 32'(bubble_cnt), 32'd7);
`endif
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
